// File: rtl/line_write_buffer.sv
// Single-entry eviction write buffer between the memory arbiter and physical memory.
// Writebacks are acknowledged on capture and drained to pmem while the port is idle.
module line_write_buffer #(
    parameter int ADDR_W   = 16,
    parameter int LINE_W   = 128,
    parameter int OFFSET_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_mem_read,
    input  logic              a_mem_write,
    input  logic [ADDR_W-1:0] a_mem_address,
    input  logic [LINE_W-1:0] a_mem_wdata,
    output logic [LINE_W-1:0] a_mem_rdata,
    output logic              a_mem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);
    localparam int TAG_W = ADDR_W - OFFSET_W;

    typedef enum logic [2:0] {IDLE, FILL, DRAIN, RESP, GAP} state_t;

    state_t            state_reg, state_next;
    logic              buf_valid_reg, buf_valid_next;
    logic [TAG_W-1:0]  buf_line_reg, buf_line_next;
    logic [LINE_W-1:0] buf_data_reg, buf_data_next;
    logic [TAG_W-1:0]  fill_line_reg, fill_line_next;
    logic [LINE_W-1:0] rdata_reg, rdata_next;
    logic              resp_read_reg, resp_read_next;

    logic [TAG_W-1:0]  req_line;
    logic              hit;
    logic              unused_offset;

    assign req_line      = a_mem_address[ADDR_W-1:OFFSET_W];
    assign hit           = buf_valid_reg && (req_line == buf_line_reg);
    assign unused_offset = ^a_mem_address[OFFSET_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            buf_valid_reg <= 1'b0;
            buf_line_reg  <= '0;
            buf_data_reg  <= '0;
            fill_line_reg <= '0;
            rdata_reg     <= '0;
            resp_read_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            buf_valid_reg <= buf_valid_next;
            buf_line_reg  <= buf_line_next;
            buf_data_reg  <= buf_data_next;
            fill_line_reg <= fill_line_next;
            rdata_reg     <= rdata_next;
            resp_read_reg <= resp_read_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        buf_valid_next = buf_valid_reg;
        buf_line_next  = buf_line_reg;
        buf_data_next  = buf_data_reg;
        fill_line_next = fill_line_reg;
        rdata_next     = rdata_reg;
        resp_read_next = resp_read_reg;
        unique case (state_reg)
            IDLE: begin
                // Reads take priority over both a pending write and a pending drain.
                if (a_mem_read) begin
                    resp_read_next = 1'b1;
                    if (hit) begin
                        rdata_next = buf_data_reg;
                        state_next = RESP;
                    end else begin
                        fill_line_next = req_line;
                        state_next     = FILL;
                    end
                end else if (a_mem_write) begin
                    if (!buf_valid_reg || hit) begin
                        buf_valid_next = 1'b1;
                        buf_line_next  = req_line;
                        buf_data_next  = a_mem_wdata;
                        resp_read_next = 1'b0;
                        state_next     = RESP;
                    end else begin
                        state_next = DRAIN;
                    end
                end else if (buf_valid_reg) begin
                    state_next = DRAIN;
                end
            end
            FILL: begin
                if (pmem_resp) begin
                    rdata_next = pmem_rdata;
                    state_next = RESP;
                end
            end
            DRAIN: begin
                if (pmem_resp) begin
                    buf_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            RESP:    state_next = GAP;
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs depend only on state and registers, so pmem signals hold steady per request.
    always_comb begin
        a_mem_resp   = (state_reg == RESP);
        a_mem_rdata  = (state_reg == RESP && resp_read_reg) ? rdata_reg : '0;
        pmem_read    = (state_reg == FILL);
        pmem_write   = (state_reg == DRAIN);
        pmem_wdata   = (state_reg == DRAIN) ? buf_data_reg : '0;
        pmem_address = '0;
        if (state_reg == FILL)
            pmem_address = {fill_line_reg, {OFFSET_W{1'b0}}};
        else if (state_reg == DRAIN)
            pmem_address = {buf_line_reg, {OFFSET_W{1'b0}}};
    end

endmodule
